debounce_pulsador: RTL



---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_pulsador_if.sv | 36 +++
 rtl/debounce_canal.sv | 158 +++++++++++++++
 rtl/debounce_pulsador.sv | 43 ++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer.
// Holds the per-channel FSM encoding and the synchronizer depth.
// Used by debounce_canal and debounce_pulsador.
package debounce_pkg;

    // Per-channel debounce FSM. The two CHECK states hold the previous
    // accepted level while the stability counter runs.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CHECK_HIGH = 2'd1,
        HIGH       = 2'd2,
        CHECK_LOW  = 2'd3
    } deb_state_t;

    // Number of flops between the raw pin and the FSM.
    localparam int SYNC_STAGES = 2;

    // Accepted (debounced) level seen from outside for a given state:
    // the button counts as pressed until a release has been confirmed.
    function automatic logic level_of(input deb_state_t s);
        return (s == HIGH) || (s == CHECK_LOW);
    endfunction

endpackage

// File: rtl/debounce_pulsador_if.sv
// Button bundle between the raw pins, the debouncer and mostrarFPGA.
// master: side that drives the pins and consumes the clean outputs.
// slave : the debouncer itself.
//
// Signal semantics (no handshake; all outputs are plain registered levels
// or one-cycle strobes in the clk domain):
//   btn_in      raw pins, asynchronous, may bounce
//   btn_level   debounced state
//   btn_press   one-cycle strobe on an accepted press (and on auto-repeat)
//   btn_release one-cycle strobe on an accepted release
//   dbg_state   current FSM state of every channel, for observation only
interface debounce_pulsador_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0]      btn_in;
    logic [N_BTN-1:0]      btn_level;
    logic [N_BTN-1:0]      btn_press;
    logic [N_BTN-1:0]      btn_release;
    logic [N_BTN-1:0][1:0] dbg_state;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  dbg_state
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output dbg_state
    );
endinterface

// File: rtl/debounce_canal.sv
// One debounced button channel: 2-flop synchronizer, stability counter,
// four-state FSM and registered press/release strobes.
// Optional auto-repeat of the press strobe under DEBOUNCE_PULSADOR_REPEAT_EN.
module debounce_canal
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [1:0] state_dbg
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s2;
    deb_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   level_next, press_next, release_next;
    logic                   rpt_fire;

    // Synchronizer: shift the raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Only the last synchronizer stage is allowed to reach the FSM.
    assign s2 = sync_q[SYNC_STAGES-1];

    // State register: FSM state and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive equal samples; any reversal drops back and clears the
    // count. The counter never wraps because the terminal value always
    // leaves the CHECK state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = CHECK_HIGH;
                    cnt_next   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_next = CHECK_LOW;
                    cnt_next   = '0;
                end
            end
            CHECK_LOW: begin
                if (s2) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_PULSADOR_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt, rpt_next;

    // Repeat interval: counts only while staying in HIGH; entering HIGH
    // (fresh press or aborted release) or leaving it restarts from zero.
    always_comb begin
        rpt_fire = 1'b0;
        rpt_next = '0;
        if ((state == HIGH) && (state_next == HIGH)) begin
            if (rpt_cnt == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_next = rpt_cnt + RPT_W'(1);
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_next;
        end
    end
`else
    // No repeat generator: the press strobe comes only from the level edge.
    // REPEAT_CYCLES is non-negative, so this is constant zero.
    assign rpt_fire = (REPEAT_CYCLES < 0);
`endif

    // Output decode: the next level follows the next state, strobes mark
    // the first cycle of a new level (plus any auto-repeat hit).
    always_comb begin
        level_next   = level_of(state_next);
        press_next   = (level_next && !btn_level) || rpt_fire;
        release_next = !level_next && btn_level;
    end

    // Output registers: nothing leaves this block combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

    assign state_dbg = state;

endmodule

// File: rtl/debounce_pulsador.sv
// Push-button conditioner in front of mostrarFPGA: N_BTN independent
// debounce_canal instances producing clean levels and press/release strobes.
// Optional feature macro: DEBOUNCE_PULSADOR_REPEAT_EN (auto-repeat of
// btn_press every REPEAT_CYCLES while a button stays held).
module debounce_pulsador
    import debounce_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    debounce_pulsador_if.slave   bus
);

    logic [N_BTN-1:0]      level_v;
    logic [N_BTN-1:0]      press_v;
    logic [N_BTN-1:0]      release_v;
    logic [N_BTN-1:0][1:0] state_v;

    // One fully independent channel per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_canal (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (bus.btn_in[i]),
            .btn_level   (level_v[i]),
            .btn_press   (press_v[i]),
            .btn_release (release_v[i]),
            .state_dbg   (state_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.dbg_state   = state_v;

endmodule
